// File: rtl/nibble_add_seq.sv
// nibble_add_seq: performs a W-bit addition (W = 4*NIBBLES) one nibble per
// cycle on an external 4-bit combinational adder.
// - The adder's carry-out is fed back as the carry-in for the next nibble.
// - Optional feature macro ADD_SEQ_OVF_EN adds a registered two's-complement
//   overflow output, ovf.
//
// Handshake: start is accepted on a rising edge while the FSM is in IDLE or
// DONE (never in RUN, and nothing is queued). done is a one-cycle valid pulse.
// sum/cout (and ovf) hold their value until the next accepted start.
module nibble_add_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [3:0]   r1,
  output logic [3:0]   r2,
  output logic         cin,
  input  logic [3:0]   result,
  input  logic         carry,
`ifdef ADD_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic [1:0]   state_dbg
);

  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic          accept;
  logic          last_nibble;

  assign accept      = start && (state == IDLE || state == DONE);
  assign last_nibble = (state == RUN) && (idx == LAST);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign state_dbg   = state;

  // State register, operand latches, nibble index and result accumulation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg     <= a;
        b_reg     <= b;
        carry_reg <= cin_in;
        idx       <= '0;
        sum       <= '0;
        cout      <= 1'b0;
      end else if (state == RUN) begin
        sum[4*idx +: 4] <= result;
        carry_reg       <= carry;
        if (idx == LAST) begin
          idx  <= '0;
          cout <= carry;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

`ifdef ADD_SEQ_OVF_EN
  // Overflow flag: the top nibble's result is still on the adder bus at the
  // final edge, so its MSB stands in for sum[W-1].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (last_nibble) begin
      ovf <= (a_reg[W-1] == b_reg[W-1]) && (result[3] != a_reg[W-1]);
    end
  end
`endif

  // Next-state logic and adder operand drive (zero outside RUN)
  always_comb begin
    state_nxt = state;
    r1        = 4'd0;
    r2        = 4'd0;
    cin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        r1  = a_reg[4*idx +: 4];
        r2  = b_reg[4*idx +: 4];
        cin = carry_reg;
        if (last_nibble) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: scoreboard bench for nibble_add_seq with NIBBLES=4 and
// a behavioural 4-bit adder closing the loop. Define ADD_SEQ_OVF_EN to also
// exercise the ovf output.
module tb_nibble_add_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   r1;
  logic [3:0]   r2;
  logic         cin;
  logic [3:0]   result;
  logic         carry;
  logic         ovf;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // expected {ovf, cout, sum}; ovf bit is 0 when the feature is off
  logic [W+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // team 4-bit adder stand-in
  assign {carry, result} = {1'b0, r1} + {1'b0, r2} + {4'b0000, cin};

`ifndef ADD_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  nibble_add_seq #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin_in    (cin_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .r1        (r1),
    .r2        (r2),
    .cin       (cin),
    .result    (result),
    .carry     (carry),
`ifdef ADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] s;
    logic       o;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef ADD_SEQ_OVF_EN
    return {o, s};
`else
    return {1'b0, s};
`endif
  endfunction

  // scoreboard: compare on every done pulse, sampled at the falling edge
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("sb_result", {46'd0, ovf, cout, sum}, {46'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic start_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(posedge clk);
    #1;
    start = 1'b1; a = x; b = y; cin_in = c;
    @(posedge clk);
    exp_q.push_back(model(x, y, c));
    #1;
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget; reports edges waited and busy cycles.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = busy ? 1 : 0;
    while (!done && n_edges < 20) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (busy) n_busy++;
    end
    if (!done) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ne, nb;

    // reset state
    #3;
    check("rst_state", {62'd0, state_dbg}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_sum_cout", {47'd0, cout, sum}, 64'd0);
    check("rst_adder_drive", {55'd0, r1, r2, cin}, 64'd0);
    do_reset();

    // 1: basic add, latency and adder drive
    start_add(16'h1234, 16'h4321, 1'b0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_drive_nib0", {55'd0, r1, r2, cin}, {55'd0, 4'h4, 4'h1, 1'b0});
    check("t1_sum_cleared", {48'd0, sum}, 64'd0);
    wait_done(ne, nb);
    check("t1_latency_edges", ne, NIB);
    check("t1_busy_cycles", nb, NIB);
    check("t1_sum", {47'd0, cout, sum}, {47'd0, 1'b0, 16'h5555});
    @(posedge clk); #1;
    check("t1_done_one_cycle", {62'd0, done, busy}, 64'd0);
    check("t1_idle_drive", {55'd0, r1, r2, cin}, 64'd0);
    check("t1_sum_held", {48'd0, sum}, {48'd0, 16'h5555});

    // 2: full carry ripple
    start_add(16'hFFFF, 16'h0001, 1'b0);
    wait_done(ne, nb);
    check("t2_sum", {47'd0, cout, sum}, {47'd0, 1'b1, 16'h0000});

    // 3: carry-in ripple, then start held high in DONE (back-to-back)
    start_add(16'hFFFF, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; a = 16'h0001; b = 16'h0002; cin_in = 1'b0;
    @(posedge clk); #1;
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_sum", {47'd0, cout, sum}, {47'd0, 1'b1, 16'h0000});
    @(posedge clk);
    exp_q.push_back(model(16'h0001, 16'h0002, 1'b0));
    #1;
    start = 1'b0;
    check("t3_b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(ne, nb);
    check("t3_b2b_latency", ne, NIB);
    check("t3_b2b_sum", {48'd0, sum}, {48'd0, 16'h0003});

    // 4: start pulsed during RUN is ignored
    start_add(16'h0F0F, 16'h1111, 1'b0);
    check("t4_busy0", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("t4_busy1", {63'd0, busy}, 64'd1);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_busy2", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("t4_busy3", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("t4_done", {62'd0, busy, done}, 64'd1);
    check("t4_sum", {47'd0, cout, sum}, {47'd0, 1'b0, 16'h2020});

    // 5: asynchronous reset mid-RUN
    start_add(16'h9876, 16'h1357, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t5_rst_state", {62'd0, state_dbg}, 64'd0);
    check("t5_rst_outputs", {45'd0, busy, done, cout, sum}, 64'd0);
    check("t5_rst_drive", {55'd0, r1, r2, cin}, 64'd0);
    exp_q.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    start_add(16'h9876, 16'h1357, 1'b1);
    wait_done(ne, nb);
    check("t5_sum", {47'd0, cout, sum}, {47'd0, 1'b0, 16'hABCE});

`ifdef ADD_SEQ_OVF_EN
    // 6: overflow flag
    start_add(16'h7FFF, 16'h0001, 1'b0);
    check("t6_ovf_cleared", {63'd0, ovf}, 64'd0);
    wait_done(ne, nb);
    check("t6a", {46'd0, ovf, cout, sum}, {46'd0, 1'b1, 1'b0, 16'h8000});
    start_add(16'h8000, 16'h8000, 1'b0);
    wait_done(ne, nb);
    check("t6b", {46'd0, ovf, cout, sum}, {46'd0, 1'b1, 1'b1, 16'h0000});
    start_add(16'h0001, 16'h0001, 1'b0);
    wait_done(ne, nb);
    check("t6c", {46'd0, ovf, cout, sum}, {46'd0, 1'b0, 1'b0, 16'h0002});
`endif

    // random operands, scoreboard-checked
    for (int i = 0; i < 20; i++) begin
      start_add(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)));
      wait_done(ne, nb);
      check("rand_latency", ne, NIB);
    end

    @(posedge clk); @(negedge clk); #1;
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
